// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared MDU opcodes, FSM states and result computation
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        we;
    } mdu_result_t;

    // we=0 marks a divide by zero: the run still happens but HI/LO keep their values.
    function automatic mdu_result_t mdu_compute(input mdu_op_e op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        mdu_result_t r;
        logic [63:0] prod;
        r    = '0;
        prod = '0;
        r.we = 1'b1;
        case (op)
            MDU_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                r.hi = prod[63:32];
                r.lo = prod[31:0];
            end
            MDU_MULT: begin
                prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r.hi = prod[63:32];
                r.lo = prod[31:0];
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    r.we = 1'b0;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    r.we = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // Quotient overflows back to the dividend; remainder is zero.
                    r.lo = a;
                    r.hi = 32'd0;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            default: r.we = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers and Busy
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [1:0]  MDUOp,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      phi_q;
    logic [31:0]      plo_q;
    logic             pwe_q;
    mdu_result_t      res_d;

    // The result is formed at the accepting edge; the run only models latency.
    assign res_d = mdu_compute(mdu_op_e'(MDUOp), A, B);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwe_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!Flush) begin
                        if (Start) begin
                            phi_q   <= res_d.hi;
                            plo_q   <= res_d.lo;
                            pwe_q   <= res_d.we;
                            cnt_q   <= MDUOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            if (HIWrite) hi_q <= A;
                            if (LOWrite) lo_q <= A;
                        end
                    end
                end
                ST_RUN: begin
                    // Inputs are ignored here; a retired op is not cancelled by Flush.
                    if (cnt_q == CNT_W'(1)) begin
                        if (pwe_q) begin
                            hi_q <= phi_q;
                            lo_q <= plo_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic [1:0]  MDUOp;
    logic        HIWrite;
    logic        LOWrite;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_vec;
    int          n_err;

    localparam int TIMEOUT = 64;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .Start  (Start),
        .MDUOp  (MDUOp),
        .HIWrite(HIWrite),
        .LOWrite(LOWrite),
        .Flush  (Flush),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    function automatic exp_t mdu_model(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] old_hi,
                                       input logic [31:0] old_lo);
        exp_t            r;
        logic [63:0]     p;
        longint          sa, sb, q, rm;
        longint unsigned ua, ub;
        r.hi = old_hi;
        r.lo = old_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = 64'(a) * 64'(b); r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b10: if (b != 0) begin r.lo = a / b; r.hi = a % b; end
            default: if (b != 0) begin
                ua = (sa < 0) ? 64'(-sa) : 64'(sa);
                ub = (sb < 0) ? 64'(-sb) : 64'(sb);
                q  = longint'(ua / ub);
                rm = longint'(ua % ub);
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) rm = -rm;
                r.lo = q[31:0];
                r.hi = rm[31:0];
            end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        Start = 1'b1; MDUOp = op; A = a; B = b;
        e = mdu_model(op, a, b, m_hi, m_lo);
        exp_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        tick();
        Start = 1'b0;
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] a);
        HIWrite = hw; LOWrite = lw; A = a;
        tick();
        HIWrite = 1'b0; LOWrite = 1'b0;
        if (hw) m_hi = a;
        if (lw) m_lo = a;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy === 1'b1 && cycles < TIMEOUT) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        n_vec++; if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h expected 0", HI); end
        n_vec++; if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h expected 0", LO); end
    endtask

    task automatic test_mult();
        logic [1:0]  ops[4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        logic [31:0] as[4]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs[4]  = '{32'd3, 32'd2, 32'h8000_0000, 32'h9ABC_DEF0};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_idle(cyc);
            n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL mult_busy[%0d]: got %0d cycles expected 5", i, cyc); end
            e = exp_q.pop_front();
            n_vec++; if (HI !== e.hi) begin n_err++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, HI, e.hi); end
            n_vec++; if (LO !== e.lo) begin n_err++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, LO, e.lo); end
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops[5] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10};
        logic [31:0] as[5]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'd100};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_idle(cyc);
            n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL div_busy[%0d]: got %0d cycles expected 10", i, cyc); end
            e = exp_q.pop_front();
            n_vec++; if (HI !== e.hi) begin n_err++; $display("FAIL div_hi[%0d]: got %h expected %h", i, HI, e.hi); end
            n_vec++; if (LO !== e.lo) begin n_err++; $display("FAIL div_lo[%0d]: got %h expected %h", i, LO, e.lo); end
        end
    endtask

    task automatic test_mthilo();
        write_hilo(1'b1, 1'b1, 32'h5A5A_A5A5);
        n_vec++; if (HI !== 32'h5A5A_A5A5) begin n_err++; $display("FAIL mtboth_hi: got %h expected 5a5aa5a5", HI); end
        n_vec++; if (LO !== 32'h5A5A_A5A5) begin n_err++; $display("FAIL mtboth_lo: got %h expected 5a5aa5a5", LO); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mt_busy: got %b expected 0", Busy); end
        write_hilo(1'b1, 1'b0, 32'h0000_0011);
        write_hilo(1'b0, 1'b1, 32'h0000_0022);
        n_vec++; if (HI !== 32'h11) begin n_err++; $display("FAIL mthi: got %h expected 00000011", HI); end
        n_vec++; if (LO !== 32'h22) begin n_err++; $display("FAIL mtlo: got %h expected 00000022", LO); end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int   cyc;
        for (int i = 0; i < 2; i++) begin
            issue(i == 0 ? 2'b11 : 2'b10, 32'h1234, 32'd0);
            wait_idle(cyc);
            n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL divz_busy[%0d]: got %0d cycles expected 10", i, cyc); end
            e = exp_q.pop_front();
            n_vec++; if (HI !== e.hi || HI !== 32'h11) begin n_err++; $display("FAIL divz_hi[%0d]: got %h expected %h", i, HI, e.hi); end
            n_vec++; if (LO !== e.lo || LO !== 32'h22) begin n_err++; $display("FAIL divz_lo[%0d]: got %h expected %h", i, LO, e.lo); end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   cyc;
        issue(2'b01, 32'd3, 32'd4);
        cyc = 0;
        while (Busy === 1'b1 && cyc < TIMEOUT) begin
            cyc++;
            if (cyc == 2) begin Start = 1'b1; MDUOp = 2'b01; A = 32'd9; B = 32'd9; end
            if (cyc == 3) begin Start = 1'b0; HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hDEAD_BEEF; end
            if (cyc == 4) begin HIWrite = 1'b0; LOWrite = 1'b0; end
            tick();
        end
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL ignore_busy: got %0d cycles expected 5", cyc); end
        e = exp_q.pop_front();
        n_vec++; if (HI !== e.hi) begin n_err++; $display("FAIL ignore_hi: got %h expected %h", HI, e.hi); end
        n_vec++; if (LO !== e.lo) begin n_err++; $display("FAIL ignore_lo: got %h expected %h", LO, e.lo); end
        tick(); tick();
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL ignore_relaunch: got %b expected 0", Busy); end
        n_vec++; if (LO !== e.lo) begin n_err++; $display("FAIL ignore_lo_after: got %h expected %h", LO, e.lo); end
    endtask

    task automatic test_flush();
        exp_t e;
        int   cyc;
        Start = 1'b1; Flush = 1'b1; MDUOp = 2'b00; A = 32'd50; B = 32'd50;
        tick();
        Start = 1'b0;
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy: got %b expected 0", Busy); end
        HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hCAFE_F00D;
        tick();
        HIWrite = 1'b0; LOWrite = 1'b0; Flush = 1'b0;
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_later: got %b expected 0", Busy); end
        n_vec++; if (HI !== m_hi) begin n_err++; $display("FAIL flush_hi: got %h expected %h", HI, m_hi); end
        n_vec++; if (LO !== m_lo) begin n_err++; $display("FAIL flush_lo: got %h expected %h", LO, m_lo); end
        issue(2'b00, 32'd7, 32'd6);
        cyc = 0;
        while (Busy === 1'b1 && cyc < TIMEOUT) begin
            cyc++;
            Flush = (cyc == 2 || cyc == 3);
            tick();
        end
        Flush = 1'b0;
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL flush_run_busy: got %0d cycles expected 5", cyc); end
        e = exp_q.pop_front();
        n_vec++; if (LO !== e.lo) begin n_err++; $display("FAIL flush_run_lo: got %h expected %h", LO, e.lo); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        exp_t        e;
        int          cyc;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            issue(op, a, b);
            wait_idle(cyc);
            n_vec++; if (cyc !== (op[1] ? 10 : 5)) begin n_err++; $display("FAIL rand_busy[%0d]: got %0d cycles op %b", i, cyc, op); end
            e = exp_q.pop_front();
            n_vec++; if (HI !== e.hi) begin n_err++; $display("FAIL rand_hi[%0d]: op %b a %h b %h got %h expected %h", i, op, a, b, HI, e.hi); end
            n_vec++; if (LO !== e.lo) begin n_err++; $display("FAIL rand_lo[%0d]: op %b a %h b %h got %h expected %h", i, op, a, b, LO, e.lo); end
        end
    endtask

    task automatic test_reset_mid();
        bit clean;
        write_hilo(1'b1, 1'b1, 32'h0BAD_0BAD);
        issue(2'b11, 32'd100, 32'd7);
        void'(exp_q.pop_back());
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        n_vec++; if (HI !== 32'd0) begin n_err++; $display("FAIL rstmid_hi: got %h expected 0", HI); end
        n_vec++; if (LO !== 32'd0) begin n_err++; $display("FAIL rstmid_lo: got %h expected 0", LO); end
        clean = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) clean = 1'b0;
        end
        n_vec++; if (clean !== 1'b1) begin n_err++; $display("FAIL rstmid_late_commit: got busy %b hi %h lo %h expected idle zeros", Busy, HI, LO); end
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; A = '0; B = '0; Start = 1'b0; MDUOp = 2'b00;
        HIWrite = 1'b0; LOWrite = 1'b0; Flush = 1'b0;
        m_hi = '0; m_lo = '0;
        #1;
        test_reset();
        test_mult();
        test_div();
        test_mthilo();
        test_div_zero();
        test_busy_ignore();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
